st7735_sequencer: RTL
=====================

Name: st7735_sequencer

Overview:
- Controls the ST7735 panel path. Runs the power-up reset and init command sequence, then one full-screen frame fill per START request.
- Drives a byte-level SPI transmitter over a valid/ready handshake. That transmitter owns CS/MOSI/LCD_CLK; this block owns DC and the panel reset pin.
- Pixels arrive from an upstream RGB565 source over a second valid/ready handshake.

Parameters:
- MS_CYCLES, 12000: SYSTEM_CLK cycles per millisecond (12 MHz). Benches shrink it, e.g. 10.
- RST_LOW_CYCLES, 120: LCD_RESET low time in cycles (10 us at 12 MHz).
- WIDTH, 128: columns.
- HEIGHT, 160: rows.

Ports:
- SYSTEM_CLK  in   1   system clock; all logic is on the rising edge.
- RESET_N     in   1   asynchronous, active-low reset.
- START       in   1   frame-fill request. Sampled as a level, acted on only in IDLE.
- LCD_RESET   out  1   panel hardware reset, active low.
- TX_DATA     out  8   byte to transmit.
- TX_DC       out  1   0 = command, 1 = data.
- TX_VALID    out  1   byte offered.
- TX_READY    in   1   transmitter accepts the byte when TX_VALID & TX_READY.
- PIX_DATA    in   16  RGB565 pixel.
- PIX_VALID   in   1   pixel offered.
- PIX_READY   out  1   pixel is accepted when PIX_VALID & PIX_READY.
- INIT_DONE   out  1   init sequence complete; stays high until reset.
- BUSY        out  1   high in every state except IDLE.
- FRAME_DONE  out  1   one-cycle pulse after the last pixel byte is accepted.

Behaviour:
- Reset values while RESET_N is low: LCD_RESET=0, TX_VALID=0, TX_DATA=0x00, TX_DC=0, PIX_READY=0, INIT_DONE=0, BUSY=1, FRAME_DONE=0, state=RST_LOW, all counters 0.
- Reset mid-operation: any in-flight byte or pixel is abandoned and the full init sequence reruns.
- Byte handshake:
  - TX_DATA and TX_DC are stable while TX_VALID=1 and TX_READY=0.
  - After each accept, TX_VALID drops for at least one cycle; the next byte follows one cycle later.
  - TX_READY while TX_VALID=0 has no effect.
- States:
  - RST_LOW: hold LCD_RESET=0 for RST_LOW_CYCLES, then set LCD_RESET=1 and go to RST_WAIT.
  - RST_WAIT: wait 120*MS_CYCLES, then INIT.
  - INIT: send the fixed table in order, as command (DC=0) or data (DC=1), waiting where listed:
    - 0x01 command, then wait 150 ms.
    - 0x11 command, then wait 120 ms.
    - 0x3A command, 0x05 data.
    - 0x36 command, 0x00 data.
    - 0x29 command, then wait 10 ms.
    - Each wait starts the cycle after that byte's accept.
    - After the final wait: INIT_DONE=1, BUSY=0, go to IDLE.
  - IDLE: if START=1, go to WIN with BUSY=1 from the next cycle.
    - START in any other state is ignored and not queued, including the cycle INIT_DONE rises.
  - WIN: send these bytes, then go to PIX_REQ with pixel counter=0:
    - 0x2A command; data 0x00, 0x00, 0x00, WIDTH-1.
    - 0x2B command; data 0x00, 0x00, 0x00, HEIGHT-1.
    - 0x2C command.
  - PIX_REQ: PIX_READY=1, TX_VALID=0.
    - On PIX_VALID & PIX_READY, latch PIX_DATA, drop PIX_READY the next cycle, go to PIX_HI.
  - PIX_HI: send PIX_DATA[15:8] with DC=1, then PIX_LO.
  - PIX_LO: send PIX_DATA[7:0] with DC=1.
    - On accept, if counter = WIDTH*HEIGHT-1: pulse FRAME_DONE for one cycle, return to IDLE, BUSY=0.
    - Otherwise increment counter and go to PIX_REQ.
- Pixel counter is 16 bits wide and never wraps within a frame; it is cleared on entry to WIN.
- Delay counter is 32 bits. A wait lasts exactly the stated number of cycles, ±1.
- PIX_READY is never high while TX_VALID=1.

Test Plan:
- Reset release, MS_CYCLES=10:
  - LCD_RESET low for exactly 120 cycles, then high.
  - First TX_VALID about 1200 cycles later with 0x01, DC=0.
- Init sequence with TX_READY always 1:
  - Accepted bytes/DC are 01/0, 11/0, 3A/0, 05/1, 36/0, 00/1, 29/0.
  - Gaps of at least 1500 cycles after 0x01 and at least 1200 after 0x11.
  - INIT_DONE rises about 100 cycles after the 0x29 accept.
- TX_READY stalls randomly 0–20 cycles:
  - TX_DATA/TX_DC never change while TX_VALID=1 and TX_READY=0.
  - The byte order is unchanged from the no-stall run.
- START in IDLE with WIDTH=2, HEIGHT=2 and pixels 0xF800, 0x07E0, 0x001F, 0xFFFF:
  - Window bytes 2A,00,00,00,01,2B,00,00,00,01,2C.
  - Pixel bytes F8,00,07,E0,00,1F,FF,FF, all DC=1.
  - FRAME_DONE pulses once, BUSY falls.
- START held high during init and during a frame: no second frame is started until IDLE is reached.
- RESET_N pulsed low in the middle of the pixel stream:
  - All outputs return to reset values asynchronously.
  - The init sequence restarts from RST_LOW.

Source files
------------

// File: rtl/st7735_sequencer.sv
// ST7735 panel sequencer: hardware reset, init command table, then one windowed
// RGB565 frame fill per START, feeding a byte-wide SPI transmitter over valid/ready.
module st7735_sequencer #(
  parameter int unsigned MS_CYCLES      = 12000,
  parameter int unsigned RST_LOW_CYCLES = 120,
  parameter int unsigned WIDTH          = 128,
  parameter int unsigned HEIGHT         = 160
) (
  input  logic        SYSTEM_CLK,
  input  logic        RESET_N,
  input  logic        START,
  output logic        LCD_RESET,
  output logic [7:0]  TX_DATA,
  output logic        TX_DC,
  output logic        TX_VALID,
  input  logic        TX_READY,
  input  logic [15:0] PIX_DATA,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic        INIT_DONE,
  output logic        BUSY,
  output logic        FRAME_DONE
);

  typedef enum logic [3:0] {
    RST_LOW, RST_WAIT, INIT, INIT_WAIT, IDLE, WIN, PIX_REQ, PIX_HI, PIX_LO
  } state_e;

  localparam logic [31:0] RST_LOW_LAST  = 32'(RST_LOW_CYCLES - 1);
  localparam logic [31:0] RST_WAIT_LAST = 32'(120 * MS_CYCLES - 1);
  localparam logic [31:0] WAIT_SWRESET  = 32'(150 * MS_CYCLES);
  localparam logic [31:0] WAIT_SLPOUT   = 32'(120 * MS_CYCLES);
  localparam logic [31:0] WAIT_DISPON   = 32'(10 * MS_CYCLES);
  localparam logic [7:0]  COL_LAST      = 8'(WIDTH - 1);
  localparam logic [7:0]  ROW_LAST      = 8'(HEIGHT - 1);
  localparam logic [15:0] PIX_LAST      = 16'(WIDTH * HEIGHT - 1);
  localparam logic [3:0]  INIT_LAST_IDX = 4'd6;
  localparam logic [3:0]  WIN_LAST_IDX  = 4'd10;

  // Table entries are {dc, byte}.
  function automatic logic [8:0] init_entry(input logic [3:0] i);
    case (i)
      4'd0:    return 9'h001;
      4'd1:    return 9'h011;
      4'd2:    return 9'h03A;
      4'd3:    return 9'h105;
      4'd4:    return 9'h036;
      4'd5:    return 9'h100;
      4'd6:    return 9'h029;
      default: return 9'h000;
    endcase
  endfunction

  // Indexed by the entry that follows the byte just accepted; zero means no wait.
  function automatic logic [31:0] init_wait(input logic [3:0] next_idx);
    case (next_idx)
      4'd1:    return WAIT_SWRESET;
      4'd2:    return WAIT_SLPOUT;
      4'd7:    return WAIT_DISPON;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [8:0] win_entry(input logic [3:0] i);
    case (i)
      4'd0:    return 9'h02A;
      4'd4:    return {1'b1, COL_LAST};
      4'd5:    return 9'h02B;
      4'd9:    return {1'b1, ROW_LAST};
      4'd10:   return 9'h02C;
      default: return 9'h100;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] pix_q, pix_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_dc_q, tx_dc_d;
  logic        lcd_rst_q, lcd_rst_d;
  logic        init_done_q, init_done_d;
  logic        frame_done_q, frame_done_d;
  logic        accept;

  assign accept = tx_valid_q & TX_READY;

  // NOTE: every _d gets its hold value first so no branch can leave one unassigned
  // and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    pix_cnt_d    = pix_cnt_q;
    pix_d        = pix_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    tx_dc_d      = tx_dc_q;
    lcd_rst_d    = lcd_rst_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;

    case (state_q)
      RST_LOW: begin
        if (cnt_q == RST_LOW_LAST) begin
          cnt_d     = '0;
          lcd_rst_d = 1'b1;
          state_d   = RST_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      RST_WAIT: begin
        if (cnt_q == RST_WAIT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      INIT: begin
        // Bytes are only raised from a dropped TX_VALID, giving the idle cycle after each accept.
        if (accept) begin
          tx_valid_d = 1'b0;
          idx_d      = idx_q + 4'd1;
          if (init_wait(idx_q + 4'd1) != 32'd0) begin
            cnt_d   = '0;
            state_d = INIT_WAIT;
          end
        end else if (!tx_valid_q) begin
          tx_valid_d           = 1'b1;
          {tx_dc_d, tx_data_d} = init_entry(idx_q);
        end
      end

      INIT_WAIT: begin
        if (cnt_q == init_wait(idx_q) - 32'd1) begin
          cnt_d = '0;
          if (idx_q > INIT_LAST_IDX) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = INIT;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      IDLE: begin
        if (START) begin
          idx_d     = '0;
          pix_cnt_d = '0;
          state_d   = WIN;
        end
      end

      WIN: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          if (idx_q == WIN_LAST_IDX) begin
            pix_cnt_d = '0;
            state_d   = PIX_REQ;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (!tx_valid_q) begin
          tx_valid_d           = 1'b1;
          {tx_dc_d, tx_data_d} = win_entry(idx_q);
        end
      end

      PIX_REQ: begin
        if (PIX_VALID) begin
          pix_d   = PIX_DATA;
          state_d = PIX_HI;
        end
      end

      PIX_HI: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          state_d    = PIX_LO;
        end else if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_dc_d    = 1'b1;
          tx_data_d  = pix_q[15:8];
        end
      end

      PIX_LO: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          if (pix_cnt_q == PIX_LAST) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            pix_cnt_d = pix_cnt_q + 16'd1;
            state_d   = PIX_REQ;
          end
        end else if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_dc_d    = 1'b1;
          tx_data_d  = pix_q[7:0];
        end
      end

      default: state_d = RST_LOW;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= RST_LOW;
      cnt_q        <= '0;
      idx_q        <= '0;
      pix_cnt_q    <= '0;
      pix_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_dc_q      <= 1'b0;
      lcd_rst_q    <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_q        <= pix_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      tx_dc_q      <= tx_dc_d;
      lcd_rst_q    <= lcd_rst_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign LCD_RESET  = lcd_rst_q;
  assign TX_DATA    = tx_data_q;
  assign TX_DC      = tx_dc_q;
  assign TX_VALID   = tx_valid_q;
  assign PIX_READY  = (state_q == PIX_REQ);
  assign INIT_DONE  = init_done_q;
  assign BUSY       = (state_q != IDLE);
  assign FRAME_DONE = frame_done_q;

endmodule
